// File: rtl/aes_inv_cipher_pkg.sv
// Shared definitions for the AES-128 inverse cipher: sizes, FSM encoding,
// GF(2^8) arithmetic, S-box byte functions, InvShiftRows/InvMixColumns and rcon.
// Everything here is pure combinational; users import aes_inv_cipher_pkg::*.
package aes_inv_cipher_pkg;

  localparam int RND_SIZE = 128;
  localparam int WRD_SIZE = 32;
  localparam int CNT_SIZE = 4;
  localparam int NUM_BLK  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] m;
    r = gf_mul(x, x);
    for (int i = 0; i < 6; i++) begin
      m = gf_mul(r, x);
      r = gf_mul(m, m);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the inverse.
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Round constant for round cnt, placed in the most significant byte.
  function automatic logic [WRD_SIZE-1:0] rcon(input logic [CNT_SIZE-1:0] cnt);
    logic [7:0] r;
    case (cnt)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return {r, 24'h000000};
  endfunction

  // Byte (row r, column c) lives at [127-8*(4c+r) -: 8]; row r rotates right by r.
  function automatic logic [RND_SIZE-1:0] inv_shiftrows(input logic [RND_SIZE-1:0] s);
    logic [RND_SIZE-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [RND_SIZE-1:0] inv_mixcolumns(input logic [RND_SIZE-1:0] s);
    logic [RND_SIZE-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box applied to each byte of a 32-bit word (InvSubBytes slice).
// Purely combinational, zero latency; no handshake.
// Instantiated once per state column.
module aes_inv_sbox
  import aes_inv_cipher_pkg::*;
(
  input  logic [WRD_SIZE-1:0] din,
  output logic [WRD_SIZE-1:0] dout
);

  // Substitute each byte independently.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = sbox_inv(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to each byte of a 32-bit word (SubWord).
// Purely combinational, zero latency; no handshake.
// Used by the reverse key schedule.
module aes_sbox
  import aes_inv_cipher_pkg::*;
(
  input  logic [WRD_SIZE-1:0] din,
  output logic [WRD_SIZE-1:0] dout
);

  // Substitute each byte independently.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = sbox_fwd(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor, one inverse round per clock, round keys derived backwards from key 10.
// Latency: o_valid rises 10 cycles after the accept edge; one block per 12 cycles at best.
// Backpressure: result held in DONE until i_out_ready; o_in_ready low whenever busy.
module aes_inv_cipher
  import aes_inv_cipher_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_in_ready,
  input  logic [RND_SIZE-1:0] i_text,
  input  logic [RND_SIZE-1:0] i_key,
  output logic                o_valid,
  input  logic                i_out_ready,
  output logic [RND_SIZE-1:0] o_text
);

  fsm_t                fsm;
  logic [RND_SIZE-1:0] state_reg;
  logic [RND_SIZE-1:0] key_reg;
  logic [CNT_SIZE-1:0] rnd_cnt;

  // Reverse key schedule: recover round key rnd_cnt-1 from round key rnd_cnt.
  logic [WRD_SIZE-1:0] w0, w1, w2, w3;
  logic [WRD_SIZE-1:0] nw0, nw1, nw2, nw3;
  logic [WRD_SIZE-1:0] sub_word;
  logic [RND_SIZE-1:0] nk;

  assign {w0, w1, w2, w3} = key_reg;
  assign nw3 = w3 ^ w2;
  assign nw2 = w2 ^ w1;
  assign nw1 = w1 ^ w0;

  aes_sbox u_key_sbox (
    .din  ({nw3[23:0], nw3[31:24]}),
    .dout (sub_word)
  );

  assign nw0 = w0 ^ sub_word ^ rcon(rnd_cnt);
  assign nk  = {nw0, nw1, nw2, nw3};

  // Round datapath: InvShiftRows, InvSubBytes per column, AddRoundKey, InvMixColumns.
  logic [RND_SIZE-1:0] shifted;
  logic [RND_SIZE-1:0] subbed;
  logic [RND_SIZE-1:0] rnd_t;
  logic [RND_SIZE-1:0] mixed;

  assign shifted = inv_shiftrows(state_reg);

  for (genvar g = 0; g < NUM_BLK; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .din  (shifted[RND_SIZE-1-WRD_SIZE*g -: WRD_SIZE]),
      .dout (subbed[RND_SIZE-1-WRD_SIZE*g -: WRD_SIZE])
    );
  end

  assign rnd_t  = subbed ^ nk;
  assign mixed  = inv_mixcolumns(rnd_t);
  assign o_text = state_reg;

  // Control FSM with registered handshake outputs; the last round skips InvMixColumns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      key_reg    <= '0;
      rnd_cnt    <= '0;
      o_in_ready <= 1'b1;
      o_valid    <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (i_valid && o_in_ready) begin
            state_reg  <= i_text ^ i_key;
            key_reg    <= i_key;
            rnd_cnt    <= 4'd10;
            fsm        <= ROUND;
            o_in_ready <= 1'b0;
          end
        end
        ROUND: begin
          if (rnd_cnt == 4'd0 || rnd_cnt > 4'd10) begin
            // Unreachable counter value: abandon the block rather than run on.
            fsm        <= IDLE;
            rnd_cnt    <= '0;
            o_in_ready <= 1'b1;
            o_valid    <= 1'b0;
          end else begin
            state_reg <= (rnd_cnt == 4'd1) ? rnd_t : mixed;
            key_reg   <= nk;
            rnd_cnt   <= rnd_cnt - 4'd1;
            if (rnd_cnt == 4'd1) begin
              fsm     <= DONE;
              o_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_out_ready) begin
            fsm        <= IDLE;
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
          end
        end
        default: begin
          fsm        <= IDLE;
          o_valid    <= 1'b0;
          o_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher using FIPS-197 vectors.
// Covers latency, backpressure, back-to-back blocks, input disturbance and mid-round reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic         o_in_ready;
  logic [127:0] i_text;
  logic [127:0] i_key;
  logic         o_valid;
  logic         i_out_ready;
  logic [127:0] o_text;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_K0  = 128'h000102030405060708090a0b0c0d0e0f;

  aes_inv_cipher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_text      (i_text),
    .i_key       (i_key),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_text      (o_text)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one block and return 1 unit after its accept edge.
  task automatic send(input logic [127:0] t, input logic [127:0] k);
    for (int n = 0; n < 50 && !o_in_ready; n++) begin
      @(posedge clk); #1;
    end
    i_valid = 1'b1;
    i_text  = t;
    i_key   = k;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Count edges until o_valid; optionally scramble the inputs meanwhile.
  task automatic wait_valid(input bit jitter, output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      if (jitter) begin
        i_text  = {$urandom, $urandom, $urandom, $urandom};
        i_key   = {$urandom, $urandom, $urandom, $urandom};
        i_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    i_valid = 1'b0;
  endtask

  task automatic take();
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           n;
    int           bad;
    int           seen;
    int           cyc;
    int           nacc;
    int           nout;
    int           out_cyc [2];
    logic [127:0] out_dat [2];
    logic [127:0] snap;
    logic [127:0] dat_now;
    bit           acc_now;
    bit           out_now;

    rst_n       = 1'b0;
    i_valid     = 1'b0;
    i_out_ready = 1'b0;
    i_text      = '0;
    i_key       = '0;
    #12;
    check("rst_o_valid", o_valid, 0);
    check("rst_in_ready", o_in_ready, 1);
    check("rst_o_text", o_text, 0);
    check("rst_key_reg", dut.key_reg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 Appendix B
    send(B_CT, B_KEY);
    check("b_busy_ready", o_in_ready, 0);
    wait_valid(1'b0, n);
    check("b_latency", n, 10);
    check("b_plain", o_text, B_PT);
    take();
    check("b_valid_drop", o_valid, 0);
    check("b_ready_back", o_in_ready, 1);

    // FIPS-197 C.1 with final key check
    send(C_CT, C_KEY);
    wait_valid(1'b0, n);
    check("c_latency", n, 10);
    check("c_plain", o_text, C_PT);
    check("c_key0", dut.key_reg, C_K0);
    take();

    // Backpressure with a competing block offered
    send(B_CT, B_KEY);
    wait_valid(1'b0, n);
    snap    = o_text;
    i_valid = 1'b1;
    i_text  = C_CT;
    i_key   = C_KEY;
    bad     = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_text !== snap || o_in_ready !== 1'b0 || o_valid !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_plain", o_text, B_PT);
    i_valid = 1'b0;
    take();
    check("bp_ready_back", o_in_ready, 1);
    check("bp_valid_drop", o_valid, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("bp_ignored", seen, 0);

    // Back-to-back: App B then C.1 with i_valid held and sink always ready
    i_out_ready = 1'b1;
    i_valid     = 1'b1;
    i_text      = B_CT;
    i_key       = B_KEY;
    cyc = 0; nacc = 0; nout = 0;
    out_cyc[0] = 0; out_cyc[1] = 0;
    out_dat[0] = '0; out_dat[1] = '0;
    while (nout < 2 && cyc < 60) begin
      acc_now = o_in_ready && i_valid;
      out_now = o_valid && i_out_ready;
      dat_now = o_text;
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        nacc++;
        if (nacc == 1) begin
          i_text = C_CT;
          i_key  = C_KEY;
        end else begin
          i_valid = 1'b0;
        end
      end
      if (out_now) begin
        out_cyc[nout] = cyc;
        out_dat[nout] = dat_now;
        nout++;
      end
    end
    i_valid     = 1'b0;
    i_out_ready = 1'b0;
    check("b2b_count", nout, 2);
    check("b2b_first", out_dat[0], B_PT);
    check("b2b_second", out_dat[1], C_PT);
    check("b2b_spacing", out_cyc[1] - out_cyc[0], 12);

    // Inputs scrambled while rounds run
    send(B_CT, B_KEY);
    wait_valid(1'b1, n);
    check("jit_latency", n, 10);
    check("jit_plain", o_text, B_PT);
    take();

    // Reset in the middle of a block
    send(C_CT, C_KEY);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_text", o_text, 0);
    check("mid_rst_ready", o_in_ready, 1);
    check("mid_rst_cnt", dut.rnd_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(B_CT, B_KEY);
    wait_valid(1'b0, n);
    check("post_rst_latency", n, 10);
    check("post_rst_plain", o_text, B_PT);
    take();
    check("post_rst_ready", o_in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
